// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data-memory request/acknowledge bus between the load/store
// stage (master) and the data memory (slave).
//
//   req    master->slave  request pending; held until ack
//   we     master->slave  request is a store
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data already placed in its byte lanes
//   wstrb  master->slave  byte enables (all zero for loads)
//   ack    slave->master  request completed this cycle
//   rdata  slave->master  load word, valid in the ack cycle
interface mem_lsu_if #(
    parameter int XLEN = 32
);
    logic                req;
    logic                we;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
    logic [XLEN/8-1:0]   wstrb;
    logic                ack;
    logic [XLEN-1:0]     rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ack, rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access pipeline stage between execute and write-back.
// Takes the EX/M bundle, performs byte/half/word loads and stores over a
// variable-latency req/ack data-memory bus, stalls upstream while an access
// is outstanding, and produces a registered M/WB bundle plus combinational
// forwarding information.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   EX/M handshake; in_ready low while an access is open
//   ex_*                EX/M bundle (address/ALU result, store data, controls)
//   dmem                data-memory bus (mem_lsu_if.master)
//   wb_*                registered M/WB bundle; wb_valid is a one-cycle pulse
//   m_fwd_wr/m_fwd_wnum pending register write of the op occupying the stage
module mem_lsu #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ex_aluresult,
    input  logic [XLEN-1:0] ex_rbdata,
    input  logic [1:0]      ex_mem_opt,
    input  logic            ex_mem_signed,
    input  logic            ex_mem_load,
    input  logic            ex_mem_wr,
    input  logic            ex_reg_wr,
    input  logic [4:0]      ex_reg_wnum,
    mem_lsu_if.master       dmem,
    output logic            wb_valid,
    output logic            wb_reg_wr,
    output logic [4:0]      wb_reg_wnum,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_exc,
    output logic [1:0]      wb_exc_cause,
    output logic            m_fwd_wr,
    output logic [4:0]      m_fwd_wnum
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    // Last wait-counter value before the request is abandoned; the request
    // is therefore visible for exactly MAX_WAIT cycles without an ack.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    function automatic logic misaligned(input logic [1:0] opt, input logic [1:0] lo);
        case (opt)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lo[0];
            default: misaligned = (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] opt, input logic [1:0] lo);
        case (opt)
            2'b00:   store_strb = 4'b0001 << lo;
            2'b01:   store_strb = 4'b0011 << lo;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    // Replicating the store data across all lanes lets the strobes alone
    // pick the target bytes.
    function automatic logic [31:0] store_lanes(input logic [1:0] opt, input logic [31:0] rb);
        case (opt)
            2'b00:   store_lanes = {4{rb[7:0]}};
            2'b01:   store_lanes = {2{rb[15:0]}};
            default: store_lanes = rb;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] opt, input logic sgn,
                                                 input logic [1:0] lo, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (opt)
            2'b00:   load_extract = {{24{sgn & b[7]}}, b};
            2'b01:   load_extract = {{16{sgn & h[15]}}, h};
            default: load_extract = rdata;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    // Operation latched for the duration of an access.
    logic [1:0]  op_q, op_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lo_q, lo_d;
    logic        store_q, store_d;
    logic        rw_q, rw_d;
    logic [4:0]  wnum_q, wnum_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_rw_q, wb_rw_d;
    logic [4:0]  wb_wnum_q, wb_wnum_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;
    logic [1:0]  wb_cause_q, wb_cause_d;

    logic        in_is_mem;
    logic        in_mis;

    // A bundle with both load and store set is handled as a store.
    assign in_is_mem = ex_mem_load | ex_mem_wr;
    assign in_mis    = in_is_mem & misaligned(ex_mem_opt, ex_aluresult[1:0]);
    assign in_ready  = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        op_d       = op_q;
        sgn_d      = sgn_q;
        lo_d       = lo_q;
        store_d    = store_q;
        rw_d       = rw_q;
        wnum_d     = wnum_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_wnum_d  = wb_wnum_q;
        wb_data_d  = wb_data_q;
        wb_exc_d   = 1'b0;
        wb_cause_d = CAUSE_NONE;
        m_fwd_wr   = 1'b0;
        m_fwd_wnum = ex_reg_wnum;

        case (state_q)
            IDLE: begin
                m_fwd_wr   = in_valid & ex_reg_wr & ~ex_mem_wr & ~in_mis;
                m_fwd_wnum = ex_reg_wnum;
                if (in_valid) begin
                    if (!in_is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = ex_reg_wr;
                        wb_wnum_d  = ex_reg_wnum;
                        wb_data_d  = ex_aluresult;
                    end else if (in_mis) begin
                        // Faulting address is reported in wb_data.
                        wb_valid_d = 1'b1;
                        wb_wnum_d  = ex_reg_wnum;
                        wb_data_d  = ex_aluresult;
                        wb_exc_d   = 1'b1;
                        wb_cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = ACCESS;
                        wait_d  = 8'd0;
                        req_d   = 1'b1;
                        we_d    = ex_mem_wr;
                        addr_d  = {ex_aluresult[31:2], 2'b00};
                        wdata_d = ex_mem_wr ? store_lanes(ex_mem_opt, ex_rbdata) : 32'd0;
                        wstrb_d = ex_mem_wr ? store_strb(ex_mem_opt, ex_aluresult[1:0]) : 4'b0000;
                        op_d    = ex_mem_opt;
                        sgn_d   = ex_mem_signed;
                        lo_d    = ex_aluresult[1:0];
                        store_d = ex_mem_wr;
                        rw_d    = ex_reg_wr;
                        wnum_d  = ex_reg_wnum;
                    end
                end
            end
            ACCESS: begin
                m_fwd_wr   = rw_q & ~store_q;
                m_fwd_wnum = wnum_q;
                // Ack is tested first so it wins over the timeout boundary.
                if (dmem.ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_rw_d    = rw_q & ~store_q;
                    wb_wnum_d  = wnum_q;
                    wb_data_d  = store_q ? 32'd0 : load_extract(op_q, sgn_q, lo_q, dmem.rdata);
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_wnum_d  = wnum_q;
                    wb_data_d  = addr_q;
                    wb_exc_d   = 1'b1;
                    wb_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_wnum_q  <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_exc_q   <= 1'b0;
            wb_cause_q <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_wnum_q  <= wb_wnum_d;
            wb_data_q  <= wb_data_d;
            wb_exc_q   <= wb_exc_d;
            wb_cause_q <= wb_cause_d;
        end
    end

    // Latched operation fields are only read in ACCESS, so they need no reset.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        sgn_q   <= sgn_d;
        lo_q    <= lo_d;
        store_q <= store_d;
        rw_q    <= rw_d;
        wnum_q  <= wnum_d;
    end

    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = addr_q;
    assign dmem.wdata   = wdata_q;
    assign dmem.wstrb   = wstrb_q;

    assign wb_valid     = wb_valid_q;
    assign wb_reg_wr    = wb_rw_q;
    assign wb_reg_wnum  = wb_wnum_q;
    assign wb_data      = wb_data_q;
    assign wb_exc       = wb_exc_q;
    assign wb_exc_cause = wb_cause_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table vectors, hand-written multi-cycle sequences and
// randomized transactions for mem_lsu. Two instances share the EX/M inputs:
// dut (MAX_WAIT=16) for normal traffic, dut_to (MAX_WAIT=4, ack never given)
// for the bus-timeout sequence.
module tb_mem_lsu;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] ex_aluresult, ex_rbdata;
    logic [1:0]  ex_mem_opt;
    logic        ex_mem_signed, ex_mem_load, ex_mem_wr, ex_reg_wr;
    logic [4:0]  ex_reg_wnum;

    logic        in_ready, wb_valid, wb_reg_wr, wb_exc, m_fwd_wr;
    logic [4:0]  wb_reg_wnum, m_fwd_wnum;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc_cause;

    logic        t_in_ready, t_wb_valid, t_wb_reg_wr, t_wb_exc, t_m_fwd_wr;
    logic [4:0]  t_wb_reg_wnum, t_m_fwd_wnum;
    logic [31:0] t_wb_data;
    logic [1:0]  t_wb_exc_cause;

    mem_lsu_if dmem_if ();
    mem_lsu_if to_if ();

    mem_lsu #(.XLEN(32), .MAX_WAIT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ex_aluresult(ex_aluresult), .ex_rbdata(ex_rbdata), .ex_mem_opt(ex_mem_opt),
        .ex_mem_signed(ex_mem_signed), .ex_mem_load(ex_mem_load), .ex_mem_wr(ex_mem_wr),
        .ex_reg_wr(ex_reg_wr), .ex_reg_wnum(ex_reg_wnum), .dmem(dmem_if),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg_wnum(wb_reg_wnum),
        .wb_data(wb_data), .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
        .m_fwd_wr(m_fwd_wr), .m_fwd_wnum(m_fwd_wnum)
    );

    mem_lsu #(.XLEN(32), .MAX_WAIT(4)) dut_to (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .ex_aluresult(ex_aluresult), .ex_rbdata(ex_rbdata), .ex_mem_opt(ex_mem_opt),
        .ex_mem_signed(ex_mem_signed), .ex_mem_load(ex_mem_load), .ex_mem_wr(ex_mem_wr),
        .ex_reg_wr(ex_reg_wr), .ex_reg_wnum(ex_reg_wnum), .dmem(to_if),
        .wb_valid(t_wb_valid), .wb_reg_wr(t_wb_reg_wr), .wb_reg_wnum(t_wb_reg_wnum),
        .wb_data(t_wb_data), .wb_exc(t_wb_exc), .wb_exc_cause(t_wb_exc_cause),
        .m_fwd_wr(t_m_fwd_wr), .m_fwd_wnum(t_m_fwd_wnum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  opt;
        logic        sgn, ld, st, rw;
        logic [4:0]  wnum;
        logic [31:0] addr, rb, rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [31:0] e_data;
        logic        e_chkdata, e_rw, e_exc;
        logic [1:0]  e_cause;
        logic        e_fwd;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derives bus and write-back expectations from the
    // access size and byte offset with plain arithmetic.
    function automatic vec_t model(input logic [1:0] opt, input logic sgn, input logic ld,
                                   input logic st, input logic rw, input logic [4:0] wnum,
                                   input logic [31:0] addr, input logic [31:0] rb,
                                   input logic [31:0] rdata);
        vec_t v;
        int unsigned size, lo;
        longint val;
        v = '{default: '0};
        v.opt = opt; v.sgn = sgn; v.ld = ld; v.st = st; v.rw = rw;
        v.wnum = wnum; v.addr = addr; v.rb = rb; v.rdata = rdata;
        size = (opt == 2'd0) ? 1 : (opt == 2'd1) ? 2 : 4;
        lo = addr % 4;
        if (!(ld || st)) begin
            v.e_data = addr; v.e_chkdata = 1'b1; v.e_rw = rw; v.e_fwd = rw;
        end else if ((addr % size) != 0) begin
            v.e_exc = 1'b1; v.e_cause = 2'd1;
        end else begin
            v.e_req = 1'b1;
            v.e_addr = addr - lo;
            v.e_we = st;
            if (st) begin
                if (size == 1)      v.e_wdata = 32'(rb[7:0]) * 32'h0101_0101;
                else if (size == 2) v.e_wdata = 32'(rb[15:0]) * 32'h0001_0001;
                else                v.e_wdata = rb;
                v.e_wstrb = 4'(((1 << size) - 1) << lo);
            end else begin
                val = (longint'(rdata) >> (8 * lo)) & ((longint'(1) << (8 * size)) - 1);
                if (sgn && size < 4 && val >= (longint'(1) << (8 * size - 1)))
                    val = val - (longint'(1) << (8 * size));
                v.e_data = 32'(val);
                v.e_chkdata = 1'b1;
                v.e_rw = rw;
                v.e_fwd = rw;
            end
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        ex_mem_opt = v.opt; ex_mem_signed = v.sgn; ex_mem_load = v.ld; ex_mem_wr = v.st;
        ex_reg_wr = v.rw; ex_reg_wnum = v.wnum; ex_aluresult = v.addr; ex_rbdata = v.rb;
    endtask

    // One bundle through the main instance; the ack arrives dly cycles after
    // the first request cycle.
    task automatic do_txn(input vec_t v, input int dly, input string tag);
        drive(v);
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".fwd_wr"}, 32'(m_fwd_wr), 32'(v.e_fwd));
        if (v.e_fwd) chk({tag, ".fwd_wnum"}, 32'(m_fwd_wnum), 32'(v.wnum));
        step();
        in_valid = 1'b0;
        if (v.e_req) begin
            for (int i = 0; i <= dly; i++) begin
                chk({tag, ".req"}, 32'(dmem_if.req), 32'd1);
                chk({tag, ".addr"}, dmem_if.addr, v.e_addr);
                if (i == 0) begin
                    chk({tag, ".we"}, 32'(dmem_if.we), 32'(v.e_we));
                    chk({tag, ".wstrb"}, 32'(dmem_if.wstrb), 32'(v.e_wstrb));
                    if (v.e_we) chk({tag, ".wdata"}, dmem_if.wdata, v.e_wdata);
                    chk({tag, ".acc_fwd_wr"}, 32'(m_fwd_wr), 32'(v.e_fwd));
                    chk({tag, ".wb_idle"}, 32'(wb_valid), 32'd0);
                end
                if (i == dly) begin
                    dmem_if.ack = 1'b1;
                    dmem_if.rdata = v.rdata;
                end
                step();
            end
            dmem_if.ack = 1'b0;
            dmem_if.rdata = 32'd0;
        end
        chk({tag, ".req_off"}, 32'(dmem_if.req), 32'd0);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_exc"}, 32'(wb_exc), 32'(v.e_exc));
        chk({tag, ".cause"}, 32'(wb_exc_cause), 32'(v.e_cause));
        chk({tag, ".wb_reg_wr"}, 32'(wb_reg_wr), 32'(v.e_rw));
        if (v.e_rw) chk({tag, ".wb_wnum"}, 32'(wb_reg_wnum), 32'(v.wnum));
        if (v.e_chkdata) chk({tag, ".wb_data"}, wb_data, v.e_data);
        chk({tag, ".ready_after"}, 32'(in_ready), 32'd1);
        step();
        chk({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int cnt_m, cnt_t, puls_m, puls_t;
        rst = 1'b1; in_valid = 1'b0;
        ex_aluresult = '0; ex_rbdata = '0; ex_mem_opt = '0; ex_mem_signed = 1'b0;
        ex_mem_load = 1'b0; ex_mem_wr = 1'b0; ex_reg_wr = 1'b0; ex_reg_wnum = '0;
        dmem_if.ack = 1'b0; dmem_if.rdata = '0; to_if.ack = 1'b0; to_if.rdata = '0;

        //        opt   sgn   ld    st    rw    wnum   addr          rb            rdata          req   we    e_addr        e_wdata       wstrb     e_data        chk   e_rw  exc   cause fwd
        tbl[0]  = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[1]  = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_0203, 32'h0,        32'h8012_3456, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'b0000, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[2]  = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6,  32'h0000_0203, 32'h0,        32'h8012_3456, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_0080, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[3]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  32'h0000_0102, 32'h0000_1234, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 32'h1234_1234, 4'b1100, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0101, 32'h0,        32'h0,         1'b0, 1'b0, 32'h0,         32'h0,        4'b0000, 32'h0,         1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[5]  = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'hCAFE_0001, 32'h5,        32'h0,         1'b0, 1'b0, 32'h0,         32'h0,        4'b0000, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[6]  = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0202, 32'h0,        32'h8012_3456, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'b0000, 32'hFFFF_8012, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 32'h0000_0201, 32'h7777_77AB, 32'h0,        1'b1, 1'b1, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[8]  = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd13, 32'h0000_0300, 32'h1122_3344, 32'h0,        1'b1, 1'b1, 32'h0000_0300, 32'h1122_3344, 4'b1111, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14, 32'h0000_0103, 32'h0000_FFFF, 32'h0,        1'b0, 1'b0, 32'h0,         32'h0,        4'b0000, 32'h0,         1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 5'd15, 32'h0000_0104, 32'h0,        32'h0BAD_F00D, 1'b1, 1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[11] = '{2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 5'd16, 32'h0000_0108, 32'hA5A5_A5A5, 32'h1,        1'b1, 1'b1, 32'h0000_0108, 32'hA5A5_A5A5, 4'b1111, 32'h0,         1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd17, 32'h0000_0200, 32'h0,        32'h1234_ABCD, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_ABCD, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[13] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd18, 32'h1234_5678, 32'h0,        32'h0,         1'b0, 1'b0, 32'h0,         32'h0,        4'b0000, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd19, 32'h0000_0201, 32'h0,        32'h0000_7F00, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_007F, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1};

        // Reset state
        step();
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.req", 32'(dmem_if.req), 32'd0);
        chk("rst.wstrb", 32'(dmem_if.wstrb), 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_exc", 32'(wb_exc), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.fwd_wr", 32'(m_fwd_wr), 32'd0);
        rst = 1'b0;
        step();

        // Table vectors, ack in the first request cycle
        for (int i = 0; i < 15; i++) do_txn(tbl[i], 0, $sformatf("vec%0d", i));

        // Ack in the very cycle the wait counter hits its limit: ack wins
        do_txn(tbl[0], 15, "ack_at_limit");

        // Ack after 5 request cycles with a second bundle waiting upstream
        v = model(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0180, 32'h0, 32'h0);
        drive(v);
        #1;
        chk("hold.ready0", 32'(in_ready), 32'd1);
        step();
        v = model(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055, 32'h0, 32'h0);
        drive(v);
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("hold.ready_low%0d", i), 32'(in_ready), 32'd0);
            chk("hold.req", 32'(dmem_if.req), 32'd1);
            chk("hold.addr", dmem_if.addr, 32'h0000_0180);
            chk("hold.fwd_wnum", 32'(m_fwd_wnum), 32'd4);
            chk("hold.fwd_wr", 32'(m_fwd_wr), 32'd1);
            if (i == 5) begin
                dmem_if.ack = 1'b1;
                dmem_if.rdata = 32'hA5A5_0F0F;
            end
            step();
        end
        dmem_if.ack = 1'b0;
        dmem_if.rdata = 32'd0;
        chk("hold.ready_back", 32'(in_ready), 32'd1);
        chk("hold.req_off", 32'(dmem_if.req), 32'd0);
        chk("hold.wb_valid", 32'(wb_valid), 32'd1);
        chk("hold.wb_data", wb_data, 32'hA5A5_0F0F);
        chk("hold.wb_wnum", 32'(wb_reg_wnum), 32'd4);
        chk("hold.fwd2_wnum", 32'(m_fwd_wnum), 32'd7);
        step();
        in_valid = 1'b0;
        chk("hold.second_valid", 32'(wb_valid), 32'd1);
        chk("hold.second_data", wb_data, 32'h0000_0055);
        chk("hold.second_wnum", 32'(wb_reg_wnum), 32'd7);
        chk("hold.second_rw", 32'(wb_reg_wr), 32'd1);
        step();
        chk("hold.pulse", 32'(wb_valid), 32'd0);

        // Reset in the second request cycle; a late ack must be ignored
        v = model(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0040, 32'h0, 32'h0);
        drive(v);
        step();
        in_valid = 1'b0;
        chk("rstacc.req1", 32'(dmem_if.req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstacc.req_off", 32'(dmem_if.req), 32'd0);
        chk("rstacc.ready", 32'(in_ready), 32'd1);
        dmem_if.ack = 1'b1;
        dmem_if.rdata = 32'h1111_1111;
        step();
        dmem_if.ack = 1'b0;
        chk("rstacc.no_wb1", 32'(wb_valid), 32'd0);
        chk("rstacc.no_req", 32'(dmem_if.req), 32'd0);
        step();
        chk("rstacc.no_wb2", 32'(wb_valid), 32'd0);

        // Bus timeout on both instances, no ack ever
        v = model(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0080, 32'h0, 32'h0);
        drive(v);
        step();
        in_valid = 1'b0;
        cnt_m = 0; cnt_t = 0; puls_m = 0; puls_t = 0;
        for (int c = 0; c < 40; c++) begin
            if (dmem_if.req) cnt_m++;
            if (to_if.req) cnt_t++;
            if (t_wb_valid) begin
                puls_t++;
                chk("to4.exc", 32'(t_wb_exc), 32'd1);
                chk("to4.cause", 32'(t_wb_exc_cause), 32'd2);
                chk("to4.reg_wr", 32'(t_wb_reg_wr), 32'd0);
                chk("to4.ready", 32'(t_in_ready), 32'd1);
            end
            if (wb_valid) begin
                puls_m++;
                chk("to16.exc", 32'(wb_exc), 32'd1);
                chk("to16.cause", 32'(wb_exc_cause), 32'd2);
                chk("to16.reg_wr", 32'(wb_reg_wr), 32'd0);
                chk("to16.ready", 32'(in_ready), 32'd1);
            end
            step();
        end
        chk("to4.req_cycles", 32'(cnt_t), 32'd4);
        chk("to16.req_cycles", 32'(cnt_m), 32'd16);
        chk("to4.pulses", 32'(puls_t), 32'd1);
        chk("to16.pulses", 32'(puls_m), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            int unsigned kind;
            logic ld, st;
            kind = $urandom_range(0, 9);
            ld = (kind < 4) || (kind == 7);
            st = (kind >= 4 && kind <= 7);
            v = model(2'($urandom_range(0, 3)), 1'($urandom), ld, st, 1'($urandom),
                      5'($urandom), $urandom, $urandom, $urandom);
            do_txn(v, int'($urandom_range(0, 5)), $sformatf("rnd%0d", n));
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk("rnd.gap_wb", 32'(wb_valid), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
